// File: rtl/imem_exec_ctrl.sv
// Execution controller for the tiny accumulator core: program loader, core gating and run/step/halt.
// Optional breakpoint support is compiled in with `define BREAKPOINT_EN.
module imem_exec_ctrl #(
  parameter int unsigned IMEM_SZ = 16,
  parameter int unsigned INST_W  = 8,
  parameter int unsigned PC_W    = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd,
  input  logic              ld_valid,
  input  logic [INST_W-1:0] ld_data,
  input  logic [PC_W-1:0]   pc_in,
  input  logic              halted_in,
  output logic              imem_we,
  output logic [PC_W-1:0]   imem_addr,
  output logic [INST_W-1:0] imem_wdata,
  output logic              core_en,
  output logic              core_rst,
  output logic              load_done,
  output logic              loaded,
  output logic [2:0]        state_out,
`ifdef BREAKPOINT_EN
  output logic              bp_hit,
`endif
  output logic [CNT_W-1:0]  cyc_cnt
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLoad = 3'd1,
    StRun  = 3'd2,
    StStep = 3'd3,
    StHalt = 3'd4
  } state_e;

  localparam logic [1:0]       CmdLoad  = 2'b00;
  localparam logic [1:0]       CmdRun   = 2'b01;
  localparam logic [1:0]       CmdStep  = 2'b10;
  localparam logic [1:0]       CmdHalt  = 2'b11;
  localparam logic [PC_W-1:0]  LastAddr = PC_W'(IMEM_SZ - 1);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  state_e             state_q;
  logic [PC_W-1:0]    addr_q;
  logic               loaded_q;
  logic               load_done_q;
  logic [CNT_W-1:0]   cnt_q;

  logic cmd_load, cmd_run, cmd_step, cmd_halt;
  logic bp_match;

  assign cmd_load = cmd_valid && (cmd == CmdLoad);
  assign cmd_run  = cmd_valid && (cmd == CmdRun);
  assign cmd_step = cmd_valid && (cmd == CmdStep);
  assign cmd_halt = cmd_valid && (cmd == CmdHalt);

`ifdef BREAKPOINT_EN
  logic [PC_W-1:0] bp_q;
  logic            bp_armed_q;
  logic            bp_skip_q;

  // The first RUN cycle after leaving HALT ignores the match so a resume can step past bp.
  assign bp_match = (state_q == StRun) && bp_armed_q && !bp_skip_q && (pc_in == bp_q);
  assign bp_hit   = bp_match;

  always_ff @(posedge clk) begin
    if (rst) begin
      bp_q       <= '0;
      bp_armed_q <= 1'b0;
      bp_skip_q  <= 1'b0;
    end else begin
      bp_skip_q <= (state_q == StHalt) && cmd_run;
      if ((state_q == StHalt) && cmd_halt && ld_valid) begin
        bp_q       <= ld_data[PC_W-1:0];
        bp_armed_q <= 1'b1;
      end
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc_in;
  assign bp_match  = 1'b0;
`endif

  assign core_rst   = (state_q == StIdle) || (state_q == StLoad);
  assign core_en    = ((state_q == StRun) && !bp_match) || (state_q == StStep);
  // An abort wins over a coincident program byte.
  assign imem_we    = (state_q == StLoad) && ld_valid && !cmd_halt;
  assign imem_addr  = addr_q;
  assign imem_wdata = ld_data;
  assign load_done  = load_done_q;
  assign loaded     = loaded_q;
  assign state_out  = state_q;
  assign cyc_cnt    = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      loaded_q    <= 1'b0;
      load_done_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      load_done_q <= 1'b0;

      if (core_rst) begin
        cnt_q <= '0;
      end else if (core_en && (cnt_q != CntMax)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (cmd_load) begin
            state_q  <= StLoad;
            addr_q   <= '0;
            loaded_q <= 1'b0;
          end else if (cmd_run && loaded_q) begin
            state_q <= StRun;
          end else if (cmd_step && loaded_q) begin
            state_q <= StStep;
          end
        end
        StLoad: begin
          if (cmd_halt) begin
            state_q  <= StIdle;
            loaded_q <= 1'b0;
          end else if (ld_valid) begin
            if (addr_q == LastAddr) begin
              addr_q      <= '0;
              state_q     <= StIdle;
              loaded_q    <= 1'b1;
              load_done_q <= 1'b1;
            end else begin
              addr_q <= addr_q + PC_W'(1);
            end
          end
        end
        StRun: begin
          if (cmd_halt || halted_in || bp_match) begin
            state_q <= StHalt;
          end
        end
        StStep: begin
          state_q <= StHalt;
        end
        StHalt: begin
          if (cmd_run) begin
            state_q <= StRun;
          end else if (cmd_step) begin
            state_q <= StStep;
          end else if (cmd_load) begin
            state_q  <= StLoad;
            addr_q   <= '0;
            loaded_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
